// File: rtl/rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_if
// Bundle of request/grant signals between a set of requesters and the
// round-robin arbiter.
//   req      : per-requester request level, held until served
//   done     : one-cycle release pulse from the current owner
//   grant    : one-hot grant (registered in the arbiter)
//   grant_id : binary index of the granted requester
//   busy     : a grant is currently held
//   timeout  : one-cycle pulse after a grant was revoked by the hold limit
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int IDW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
  logic [WIDTH-1:0] req;
  logic             done;
  logic [WIDTH-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic             busy;
  logic             timeout;

  modport master (output req, done, input grant, grant_id, busy, timeout);
  modport slave  (input req, done, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a bounded hold time. A two-state FSM (IDLE/GRANT)
// issues one registered one-hot grant at a time. Priority rotates downward:
// the winner is the highest requesting index below the previous winner,
// wrapping to the highest requesting index overall. A grant ends on done,
// on the owner dropping its request, or after MAX_HOLD cycles; at least one
// IDLE cycle separates consecutive grants.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_arbiter_if.slave (req/done in, grant/grant_id/busy/timeout out)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);

  localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW  = $clog2(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Winner search: two priority encoders over req, one restricted to indices
  // below last_q and one unrestricted for the wrap-around case.
  logic [IDW-1:0] lo_id, hi_id, pick;
  logic           lo_found;

  always_comb begin
    lo_id    = '0;
    hi_id    = '0;
    lo_found = 1'b0;
    // Ascending scan: the last hit is the highest set index.
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.req[i]) begin
        hi_id = IDW'(i);
        if (i < int'(last_q)) begin
          lo_id    = IDW'(i);
          lo_found = 1'b1;
        end
      end
    end
    pick = lo_found ? lo_id : hi_id;
  end

  // Release terms, evaluated only while in GRANT.
  logic at_limit, owner_done, owner_drop;
  assign at_limit   = (cnt_q == CW'(MAX_HOLD - 1));
  assign owner_done = bus.done;
  assign owner_drop = !bus.req[id_q];

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|bus.req) begin
          state_d       = GRANT;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          id_d          = pick;
          last_d        = pick;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (owner_done || owner_drop || at_limit) begin
          state_d   = IDLE;
          grant_d   = '0;
          cnt_d     = '0;
          // Only a pure hold-limit revocation is reported.
          timeout_d = at_limit && !owner_done && !owner_drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reset is in the sensitivity list, so the outputs clear as soon
  // as rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.busy     = (state_q == GRANT);
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
// Scoreboard bench for rr_arbiter. Stimulus pushes the expected grant_id of
// each upcoming grant into a queue; a monitor per DUT pops and compares on
// every new grant and checks the output invariants each cycle. Two DUTs:
// WIDTH=8 and WIDTH=5, both MAX_HOLD=16.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_if #(.WIDTH(8)) bus8 ();
  rr_arbiter_if #(.WIDTH(5)) bus5 ();

  rr_arbiter #(.WIDTH(8), .MAX_HOLD(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  rr_arbiter #(.WIDTH(5), .MAX_HOLD(16)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  int tests  = 0;
  int errors = 0;
  int q8[$];
  int q5[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon8
    logic prev = 1'b0;
    int   e;
    forever begin
      @(negedge clk);
      check("inv8_onehot0", int'($onehot0(bus8.grant)), 1);
      check("inv8_grant_busy", int'(bus8.grant[bus8.grant_id]), int'(bus8.busy));
      if (bus8.busy && !prev) begin
        if (q8.size() == 0) begin
          check("grant8_unexpected", 1, 0);
        end else begin
          e = q8.pop_front();
          check("grant8_id", int'(bus8.grant_id), e);
          check("grant8_vec", int'(bus8.grant), 1 << e);
        end
      end
      prev = bus8.busy;
    end
  end

  initial begin : mon5
    logic prev = 1'b0;
    int   e;
    forever begin
      @(negedge clk);
      check("inv5_onehot0", int'($onehot0(bus5.grant)), 1);
      check("inv5_grant_busy", int'(bus5.grant[bus5.grant_id]), int'(bus5.busy));
      if (bus5.busy && !prev) begin
        if (q5.size() == 0) begin
          check("grant5_unexpected", 1, 0);
        end else begin
          e = q5.pop_front();
          check("grant5_id", int'(bus5.grant_id), e);
          check("grant5_vec", int'(bus5.grant), 1 << e);
        end
      end
      prev = bus5.busy;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_busy(input int which);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (which == 8 && bus8.busy) return;
      if (which == 5 && bus5.busy) return;
    end
    check($sformatf("wait_busy%0d_timeout", which), 0, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst       = 1'b1;
    bus8.req  = '0;
    bus8.done = 1'b0;
    bus5.req  = '0;
    bus5.done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    bus8.req  = '0;
    bus8.done = 1'b0;
    bus5.req  = '0;
    bus5.done = 1'b0;

    // Reset values before any clock edge.
    #1;
    check("rst_grant", int'(bus8.grant), 0);
    check("rst_grant_id", int'(bus8.grant_id), 0);
    check("rst_busy", int'(bus8.busy), 0);
    check("rst_timeout", int'(bus8.timeout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic grant: 8'h05 -> id 2.
    q8.push_back(2);
    bus8.req = 8'h05;
    @(negedge clk);
    check("basic_grant", int'(bus8.grant), 8'h04);
    check("basic_busy", int'(bus8.busy), 1);
    bus8.req = '0;
    @(negedge clk);
    check("basic_release", int'(bus8.busy), 0);

    // Rotation: 7..0 then wrap to 7, one idle cycle between grants.
    reset_dut();
    bus8.req = 8'hFF;
    for (int k = 0; k < 9; k++) q8.push_back((k < 8) ? 7 - k : 7);
    for (int k = 0; k < 9; k++) begin
      wait_busy(8);
      bus8.done = 1'b1;
      if (k == 8) bus8.req = '0;
      @(negedge clk);
      bus8.done = 1'b0;
      check("rot_idle_gap", int'(bus8.busy), 0);
    end

    // Hold limit: 16 cycles, timeout pulse during the idle cycle, regrant 0.
    reset_dut();
    q8.push_back(0);
    q8.push_back(0);
    q8.push_back(0);
    bus8.req = 8'h01;
    wait_busy(8);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus8.busy) break;
      n++;
    end
    check("hold_len", n, 16);
    check("hold_timeout", int'(bus8.timeout), 1);
    check("hold_idle_grant", int'(bus8.grant), 0);
    @(negedge clk);
    check("hold_timeout_clr", int'(bus8.timeout), 0);
    check("hold_regrant", int'(bus8.busy), 1);

    // done coinciding with the limit: no timeout.
    for (int i = 0; i < 15; i++) @(negedge clk);
    bus8.done = 1'b1;
    @(negedge clk);
    bus8.done = 1'b0;
    check("limit_done_busy", int'(bus8.busy), 0);
    check("limit_done_timeout", int'(bus8.timeout), 0);

    // Third grant of id 0, ended by dropping the request.
    wait_busy(8);
    bus8.req = '0;
    @(negedge clk);
    check("drop0_busy", int'(bus8.busy), 0);

    // done is ignored in IDLE.
    bus8.done = 1'b1;
    @(negedge clk);
    bus8.done = 1'b0;
    check("idle_done_busy", int'(bus8.busy), 0);
    @(negedge clk);
    check("idle_done_busy2", int'(bus8.busy), 0);

    // Requester drop on id 3: no timeout.
    q8.push_back(3);
    bus8.req = 8'h08;
    wait_busy(8);
    check("drop3_id", int'(bus8.grant_id), 3);
    bus8.req = '0;
    @(negedge clk);
    check("drop3_grant", int'(bus8.grant), 0);
    check("drop3_timeout", int'(bus8.timeout), 0);
    check("drop3_id_hold", int'(bus8.grant_id), 3);

    // Reset mid-grant: outputs clear without a clock edge, last_id restarts.
    q8.push_back(3);
    bus8.req = 8'h08;
    wait_busy(8);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_grant", int'(bus8.grant), 0);
    check("midrst_busy", int'(bus8.busy), 0);
    check("midrst_id", int'(bus8.grant_id), 0);
    q8.push_back(7);
    bus8.req = 8'h81;
    @(negedge clk);
    rst = 1'b0;
    wait_busy(8);
    bus8.req = '0;
    @(negedge clk);

    // Non-power-of-two width: 5'b10010 -> 4, then 1.
    q5.push_back(4);
    q5.push_back(1);
    bus5.req = 5'b10010;
    wait_busy(5);
    bus5.done = 1'b1;
    @(negedge clk);
    bus5.done = 1'b0;
    wait_busy(5);
    bus5.done = 1'b1;
    bus5.req  = '0;
    @(negedge clk);
    bus5.done = 1'b0;
    check("w5_release", int'(bus5.busy), 0);

    repeat (3) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q5_drained", q5.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, number of requesters, SHALL be at least 2 and need not be a power of two.
REQ-002 Parameter: MAX_HOLD, default 16, maximum grant length in cycles, SHALL be at least 2.
REQ-003 Derived: IDW = ceil(log2(WIDTH)), the width of grant_id.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  WIDTH  per-requester request level; requester holds it until served.
REQ-007 done  input  1  single-cycle pulse from the current owner releasing the shared resource.
REQ-008 grant  output  WIDTH  one-hot grant, registered.
REQ-009 grant_id  output  IDW  binary index of the granted requester, registered.
REQ-010 busy  output  1  high while any grant is held.
REQ-011 timeout  output  1  single-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-013 IDLE: if req is nonzero at a clock edge, the FSM SHALL enter GRANT, with grant, grant_id and busy valid after that edge (1-cycle latency).
REQ-014 IDLE: if req is zero, the FSM SHALL stay in IDLE with grant = 0.
REQ-015 Winner selection: the winner SHALL be the highest set index of req restricted to indices strictly below last_id.
REQ-016 Winner selection fallback: if that restricted set is empty, the winner SHALL be the highest set index of the full req vector (wrap-around).
REQ-017 last_id SHALL be loaded with the winner's index when the grant is issued.
REQ-018 GRANT: grant and grant_id SHALL remain stable; changes on other req bits SHALL be ignored.
REQ-019 Hold counter: a counter of width ceil(log2(MAX_HOLD)) SHALL clear on grant entry and increment each cycle in GRANT.
REQ-020 Release: the FSM SHALL return to IDLE at the next edge when done = 1, req[grant_id] = 0, or the hold counter equals MAX_HOLD-1.
REQ-021 On release, grant and busy SHALL be 0 after the releasing edge.
REQ-022 The FSM SHALL spend at least one cycle in IDLE between grants (no back-to-back grants).
REQ-023 timeout SHALL pulse for exactly the one cycle following a release caused only by the hold limit.
REQ-024 timeout SHALL stay low when done = 1 or req[grant_id] = 0 coincides with the limit.
REQ-025 done SHALL be ignored in IDLE.
REQ-026 Output invariants: grant SHALL be all-zero or exactly one-hot, and grant[grant_id] = busy at all times.
REQ-027 When busy = 0, grant_id SHALL hold its last value.

Reset
REQ-028 While rst = 1, without waiting for a clock edge: state = IDLE, grant = 0, grant_id = 0, busy = 0, timeout = 0, hold counter = 0, last_id = 0.
REQ-029 Reset asserted mid-grant SHALL abort the grant immediately; the first arbitration after reset release SHALL use last_id = 0.

Verification (WIDTH=8, MAX_HOLD=16 unless stated)
REQ-030 Basic grant: reset, then req = 8'h05 -> one edge later grant = 8'h04, grant_id = 2, busy = 1.
REQ-031 Rotation: req = 8'hFF held, done pulsed once per grant -> grant_id sequence 7,6,5,4,3,2,1,0,7, with one idle cycle between grants.
REQ-032 Hold limit: req = 8'h01 held, no done -> grant held 16 cycles, timeout high for 1 cycle, grant 0 for 1 cycle, then grant_id 0 again.
REQ-033 Requester drop: grant_id = 3, req[3] deasserted -> grant = 0 next edge, timeout stays 0.
REQ-034 Reset mid-grant: rst asserted mid-grant -> grant = 0, busy = 0 with no clock edge; after release, req = 8'h81 -> grant_id 7.
REQ-035 Non-power-of-two: WIDTH=5, req = 5'b10010 -> grant_id 4, then after done, grant_id 1.
